// File: rtl/filterbank_mac.sv
// Time-multiplexed FIR filter bank: one shared sample delay line feeding NCH
// parallel multiply-accumulate pipelines that step through NTAPS taps per sample.
module filterbank_mac #(
    parameter int NCH    = 8,
    parameter int NTAPS  = 64,
    parameter int DW     = 16,
    parameter int CW     = 36,
    parameter int OSHIFT = 35
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [DW-1:0]            datain,
    input  logic                     din_enable,
    output logic                     busy,
    output logic                     overrun,
    output logic [$clog2(NTAPS)-1:0] coeffaddress,
    input  logic [NCH*CW-1:0]        coeffs,
    output logic [NCH*DW-1:0]        dataout,
    output logic                     dout_valid
);
    localparam int AW  = $clog2(NTAPS);
    localparam int PW  = DW + CW;
    localparam int ACW = DW + CW + AW;
    localparam logic [AW-1:0] LAST_TAP  = AW'(NTAPS - 1);
    localparam logic [AW-1:0] DRAIN_END = AW'(2);
    localparam logic [AW-1:0] ONE       = AW'(1);
    localparam logic signed [ACW:0] RND  = (ACW+1)'(1) <<< (OSHIFT - 1);
    localparam logic signed [ACW:0] YMAX = (ACW+1)'((2 ** (DW - 1)) - 1);
    localparam logic signed [ACW:0] YMIN = ~YMAX;
    localparam int TV = 2;
    localparam int TF = 1;
    localparam int TL = 0;

    typedef enum logic [1:0] {CLEAR, IDLE, RUN, DRAIN} state_t;

    state_t                state_q, state_d;
    logic [AW-1:0]         cnt_q, cnt_d;
    logic [AW-1:0]         wptr_q, wptr_d;
    logic [AW-1:0]         base_q, base_d;
    logic                  overrun_q, overrun_d;
    logic [DW-1:0]         dline_q [NTAPS];
    logic [DW-1:0]         dline_d [NTAPS];
    logic [2:0]            tag0_q, tag0_d, tag1_q, tag1_d, tag2_q, tag2_d;
    logic signed [DW-1:0]  samp0_q, samp0_d, samp1_q, samp1_d;
    logic signed [CW-1:0]  coef1_q [NCH];
    logic signed [CW-1:0]  coef1_d [NCH];
    logic signed [PW-1:0]  prod2_q [NCH];
    logic signed [PW-1:0]  prod2_d [NCH];
    logic signed [ACW-1:0] acc_q [NCH];
    logic signed [ACW-1:0] acc_d [NCH];
    logic [DW-1:0]         dout_q [NCH];
    logic [DW-1:0]         dout_d [NCH];
    logic                  dout_valid_q, dout_valid_d;

    function automatic logic [DW-1:0] round_sat(input logic signed [ACW-1:0] a);
        logic signed [ACW:0] y;
        y = ((ACW+1)'(a) + RND) >>> OSHIFT;
        if (y > YMAX) return YMAX[DW-1:0];
        if (y < YMIN) return YMIN[DW-1:0];
        return y[DW-1:0];
    endfunction

    // Sequencer: cnt_q is the clear index in CLEAR, the tap index in RUN and
    // the flush counter in DRAIN.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wptr_d    = wptr_q;
        base_d    = base_q;
        overrun_d = overrun_q | (din_enable & (state_q != IDLE));
        dline_d   = dline_q;
        tag0_d    = 3'b000;
        case (state_q)
            CLEAR: begin
                dline_d[cnt_q] = '0;
                cnt_d = cnt_q + ONE;
                if (cnt_q == LAST_TAP) state_d = IDLE;
            end
            IDLE: begin
                if (din_enable) begin
                    dline_d[wptr_q] = datain;
                    base_d  = wptr_q;
                    wptr_d  = wptr_q + ONE;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                tag0_d = {1'b1, cnt_q == '0, cnt_q == LAST_TAP};
                cnt_d  = cnt_q + ONE;
                if (cnt_q == LAST_TAP) state_d = DRAIN;
            end
            DRAIN: begin
                cnt_d = cnt_q + ONE;
                if (cnt_q == DRAIN_END) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    // Tags {valid, first, last} travel with each tap so the accumulator knows
    // when to restart and when the final sum is ready for the output stage.
    always_comb begin
        samp0_d      = dline_q[base_q - cnt_q];
        samp1_d      = samp0_q;
        tag1_d       = tag0_q;
        tag2_d       = tag1_q;
        dout_valid_d = tag2_q[TV] & tag2_q[TL];
        for (int c = 0; c < NCH; c++) begin
            coef1_d[c] = coeffs[c*CW +: CW];
            prod2_d[c] = PW'(samp1_q) * PW'(coef1_q[c]);
            acc_d[c]   = acc_q[c];
            if (tag2_q[TV]) begin
                acc_d[c] = (tag2_q[TF] ? ACW'(0) : acc_q[c]) + ACW'(prod2_q[c]);
            end
            dout_d[c] = dout_valid_d ? round_sat(acc_d[c]) : dout_q[c];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= CLEAR;
            cnt_q        <= '0;
            wptr_q       <= '0;
            base_q       <= '0;
            overrun_q    <= 1'b0;
            tag0_q       <= 3'b000;
            tag1_q       <= 3'b000;
            tag2_q       <= 3'b000;
            dout_valid_q <= 1'b0;
            for (int c = 0; c < NCH; c++) begin
                acc_q[c]  <= '0;
                dout_q[c] <= '0;
            end
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wptr_q       <= wptr_d;
            base_q       <= base_d;
            overrun_q    <= overrun_d;
            tag0_q       <= tag0_d;
            tag1_q       <= tag1_d;
            tag2_q       <= tag2_d;
            dout_valid_q <= dout_valid_d;
            acc_q        <= acc_d;
            dout_q       <= dout_d;
        end
    end

    // Pure datapath registers; CLEAR zeroes the delay line after reset.
    always_ff @(posedge clock) begin
        dline_q <= dline_d;
        samp0_q <= samp0_d;
        samp1_q <= samp1_d;
        coef1_q <= coef1_d;
        prod2_q <= prod2_d;
    end

    assign busy         = (state_q != IDLE);
    assign overrun      = overrun_q;
    assign coeffaddress = (state_q == RUN) ? cnt_q : '0;
    assign dout_valid   = dout_valid_q;

    for (genvar c = 0; c < NCH; c++) begin : g_out
        assign dataout[c*DW +: DW] = dout_q[c];
    end

endmodule
